adder_sched: RTL and testbench
==============================

# adder_sched

Round-robin scheduler that shares one combinational 8-bit adder (`adder8b`) among `NREQ` requesters. It arbitrates incoming add requests, latches the winner's operands, and drives them onto the shared adder. It registers the adder result and returns it on a single response channel tagged with the requester ID. It sits between client blocks and the adder instance; clients never drive the adder directly.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..4)
- `IDW`, 2, width of requester ID; `NREQ <= 2**IDW`

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request strobe
- `req_ready`  out  NREQ  one-hot grant/accept; request i accepted when `req_valid[i] && req_ready[i]`
- `req_a`, `req_b`  in  8*NREQ  packed operands; requester i occupies slice [8*i +: 8]
- `req_cin`  in  NREQ  per-requester carry-in
- `add_a`, `add_b`  out  8  operands to shared adder (registered)
- `add_cin`  out  1  carry-in to shared adder (registered)
- `add_sum`  in  8  adder sum
- `add_cout`  in  1  adder carry-out
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  index of requester that owns the response
- `rsp_sum`  out  8  registered sum
- `rsp_cout`  out  1  registered carry-out

Operands use the adder's `[0:7]` ordering (bit 0 = MSB), passed unchanged.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: winner = first i with `req_valid[i]`, searching from `ptr+1` modulo NREQ. `req_ready[winner]` = 1 combinationally; all others 0. On the edge, capture `req_a/req_b/req_cin` of the winner into `add_a/add_b/add_cin` and the ID into `rsp_id`, then go to CALC. With no valid request, stay in IDLE and hold `req_ready` = 0.
- CALC: the adder settles on the registered operands. Capture `add_sum` into `rsp_sum` and `add_cout` into `rsp_cout`, then go to RESP.
- RESP: `rsp_valid` = 1. Outputs are held stable until `rsp_ready` = 1. On handshake, `ptr <= rsp_id`, `rsp_valid` drops next cycle, and the FSM returns to IDLE.
- `req_ready` is 0 in CALC and RESP, so only one transaction is in flight at a time.
- Arithmetic: 9-bit result {cout, sum} = a + b + cin, computed entirely by the external adder. The scheduler does no arithmetic.
- Reset (sync, `rst`=1 at an edge): state = IDLE, `ptr` = NREQ-1 (requester 0 has first priority). `add_a`, `add_b`, `add_cin`, `rsp_sum`, `rsp_cout`, `rsp_id`, and `rsp_valid` are all 0. `req_ready` is forced to 0 while `rst`=1. Reset mid-transaction drops it silently; no response is issued.
- Requesters must hold `req_valid` and operands stable until accepted. Dropping valid before grant is legal and causes no capture.

## Timing
- Accept-to-`rsp_valid` latency: 2 cycles. Accepted at edge N, result captured at edge N+1, `rsp_valid` high after edge N+1.
- Peak throughput: one add per 3 cycles, given `rsp_ready` held high.
- Backpressure: `rsp_ready` low stalls in RESP indefinitely with outputs constant.
- Fairness: the last-served requester is lowest priority on the next arbitration. With all NREQ=4 requesters valid, grants go 0,1,2,3,0,…
- Simultaneous `rsp_ready` handshake and new `req_valid`: the new request is granted in the following IDLE cycle, not the same cycle.

## Configuration
- `ADDER_SCHED_LOCK_EN` defined: adds input `req_lock` (NREQ), used for multi-byte carry chaining.
  - If the captured request has `req_lock`=1, the next IDLE grants the same requester regardless of RR order, provided its `req_valid`=1. In that case `add_cin` is taken from the stored `rsp_cout`, and `req_cin` is ignored.
  - The lock is released when a captured request has `req_lock`=0, or when the locked requester is not valid in IDLE. In that case normal RR resumes from `ptr`.
  - Reset clears the lock.
- Not defined: no `req_lock` port, pure RR, `add_cin` always from `req_cin`.

## Test plan
- Single request: req0 a=0x03, b=0x04, cin=1. Expected: `req_ready`=0001 in IDLE; 2 cycles later `rsp_valid`=1, id=0, sum=0x08, cout=0.
- Overflow: req2 a=0xFF, b=0x01, cin=0. Expected: sum=0x00, cout=1, id=2.
- All four requesters valid continuously with `rsp_ready`=1. Expected: grant order 0,1,2,3,0; one response every 3 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with req1 pending behind an in-flight req0 (a=0x0D, b=0x01). Expected: sum=0x0E held stable and `req_ready` stays 0 until the handshake; req1 is granted in the cycle after.
- Assert `rst` in CALC. Expected: next cycle state IDLE, `rsp_valid`=0, all outputs 0; the next grant goes to requester 0.
- (LOCK_EN) req1 with lock=1 sends a=0xF0, b=0x20, cin=0, then lock=0 sends a=0x01, b=0x01, while req0 is also valid. Expected: responses sum=0x10 cout=1, then sum=0x03 cout=0, both id=1; req0 is served next.

Source files
------------

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one external 8-bit adder among NREQ requesters.
// Optional carry-chaining lock: define ADDER_SCHED_LOCK_EN to add the req_lock input.
module adder_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADDER_SCHED_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [0:7]        add_a,
  output logic [0:7]        add_b,
  output logic              add_cin,
  input  logic [0:7]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [0:7]        rsp_sum,
  output logic              rsp_cout
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           win_found;
  logic           win_cin;

`ifdef ADDER_SCHED_LOCK_EN
  logic lock_q;
  logic lock_hit;
`endif

  // Arbitration: a held lock on a still-valid requester overrides round-robin order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
    win_cin = req_cin[win];
`ifdef ADDER_SCHED_LOCK_EN
    lock_hit = lock_q && req_valid[rsp_id];
    if (lock_hit) begin
      win       = rsp_id;
      win_found = 1'b1;
      win_cin   = rsp_cout;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win] = 1'b1;
          state_nxt      = CALC;
        end
      end
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  assign rsp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(NREQ - 1);
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef ADDER_SCHED_LOCK_EN
          if (lock_q && !lock_hit) lock_q <= 1'b0;
`endif
          if (win_found) begin
            add_a   <= req_a[8*int'(win) +: 8];
            add_b   <= req_b[8*int'(win) +: 8];
            add_cin <= win_cin;
            rsp_id  <= win;
`ifdef ADDER_SCHED_LOCK_EN
            lock_q  <= req_lock[win];
`endif
          end
        end
        CALC: begin
          rsp_sum  <= add_sum;
          rsp_cout <= add_cout;
        end
        RESP: begin
          if (rsp_ready) ptr <= rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Directed self-checking bench for adder_sched with a behavioural model of the shared adder.
// Lock sequence runs only when ADDER_SCHED_LOCK_EN is defined.
module tb_adder_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_cin;
`ifdef ADDER_SCHED_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [0:7]        add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [0:7]        rsp_sum;
  logic              rsp_cout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  adder_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef ADDER_SCHED_LOCK_EN
    .req_lock(req_lock),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_cin[i]      = cin;
  endtask

  logic [7:0] rr_sum [4] = '{8'h01, 8'h12, 8'h23, 8'h34};

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
`ifdef ADDER_SCHED_LOCK_EN
    req_lock  = '0;
`endif
    set_req(0, 8'h03, 8'h04, 1'b1);
    tick();
    tick();
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_add_a", add_a, 8'h00);
    check("rst_rsp_sum", rsp_sum, 8'h00);

    // Single request on requester 0.
    rst = 1'b0;
    #1;
    check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check("single_calc_valid", rsp_valid, 1'b0);
    check("single_add_a", add_a, 8'h03);
    check("single_calc_ready", req_ready, 4'b0000);
    tick();
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 2'd0);
    check("single_sum", rsp_sum, 8'h08);
    check("single_cout", rsp_cout, 1'b0);
    tick();
    check("single_rsp_drop", rsp_valid, 1'b0);

    // Overflow on requester 2.
    set_req(2, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0100;
    #1;
    check("ovf_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    check("ovf_sum", rsp_sum, 8'h00);
    check("ovf_cout", rsp_cout, 1'b1);
    check("ovf_id", rsp_id, 2'd2);
    tick();

    // Reset while a transaction sits in CALC.
    set_req(1, 8'h05, 8'h05, 1'b1);
    req_valid = 4'b0010;
    #1;
    check("midrst_ready", req_ready, 4'b0010);
    tick();
    check("midrst_add_a", add_a, 8'h05);
    req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_add_b", add_b, 8'h00);
    check("midrst_add_cin", add_cin, 1'b0);
    check("midrst_rsp_id", rsp_id, 2'd0);
    check("midrst_rsp_sum", rsp_sum, 8'h00);
    check("midrst_rsp_cout", rsp_cout, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_no_rsp", rsp_valid, 1'b0);

    // All four valid continuously: grants 0,1,2,3,0 with a response every 3 cycles.
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * i + 1), 8'(i), 1'b0);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      check($sformatf("rr%0d_idle_valid", n), rsp_valid, 1'b0);
      check($sformatf("rr%0d_grant", n), req_ready, 32'(4'b0001 << (n % 4)));
      tick();
      tick();
      check($sformatf("rr%0d_valid", n), rsp_valid, 1'b1);
      check($sformatf("rr%0d_id", n), rsp_id, 32'(n % 4));
      check($sformatf("rr%0d_sum", n), rsp_sum, rr_sum[n % 4]);
      tick();
    end
    req_valid = 4'b0000;

    // Backpressure: req0 in flight, req1 waiting, consumer stalls 5 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 8'h0D, 8'h01, 1'b0);
    set_req(1, 8'h20, 8'h05, 1'b1);
    req_valid = 4'b0011;
    #1;
    check("bp_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      check($sformatf("bp_hold%0d_valid", n), rsp_valid, 1'b1);
      check($sformatf("bp_hold%0d_sum", n), rsp_sum, 8'h0E);
      check($sformatf("bp_hold%0d_ready", n), req_ready, 4'b0000);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready", req_ready, 4'b0000);
    tick();
    check("bp_after_valid", rsp_valid, 1'b0);
    check("bp_grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    check("bp_r1_id", rsp_id, 2'd1);
    check("bp_r1_sum", rsp_sum, 8'h26);
    check("bp_r1_cout", rsp_cout, 1'b0);
    tick();

`ifdef ADDER_SCHED_LOCK_EN
    // Two-byte carry chain on requester 1 while requester 0 also waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 8'h01, 8'h02, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    check("lk_pre_sum", rsp_sum, 8'h03);
    tick();
    set_req(0, 8'h40, 8'h02, 1'b0);
    set_req(1, 8'hF0, 8'h20, 1'b0);
    req_lock  = 4'b0010;
    req_valid = 4'b0011;
    #1;
    check("lk_grant1", req_ready, 4'b0010);
    tick();
    set_req(1, 8'h01, 8'h01, 1'b0);
    req_lock = 4'b0000;
    tick();
    check("lk_b0_sum", rsp_sum, 8'h10);
    check("lk_b0_cout", rsp_cout, 1'b1);
    check("lk_b0_id", rsp_id, 2'd1);
    tick();
    check("lk_regrant1", req_ready, 4'b0010);
    tick();
    check("lk_chain_cin", add_cin, 1'b1);
    req_valid = 4'b0001;
    tick();
    check("lk_b1_sum", rsp_sum, 8'h03);
    check("lk_b1_cout", rsp_cout, 1'b0);
    check("lk_b1_id", rsp_id, 2'd1);
    tick();
    check("lk_release_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    check("lk_r0_sum", rsp_sum, 8'h42);
    check("lk_r0_id", rsp_id, 2'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
